frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Per-frame sequencer for the SDRAM frame-buffer drawing clients: the background/DFJK-lane drawer and the sprite drawer.
- On each vertical-blank pulse from the VGA side, it flips the double buffer, then starts the background pass and the sprite pass in strict order.
- It detects frame overruns and task hangs, and exposes frame and overrun counters for the HEX/LED debug path.
- Sits between the VGA timing logic and the drawing clients; SDRAM access arbitration is handled elsewhere.

Parameters:
- TIMEOUT_CYCLES, 1000000, maximum clk cycles a task may take, counted from its start pulse to its done pulse, before it is aborted.
- CNT_W, 16, width of frame_count.

Ports:
- clk  input  1  50 MHz system clock
- reset  input  1  synchronous, active-high reset
- new_frame  input  1  vblank marker from the pixel-clock domain; high for 2 clk cycles per frame; same clock source as clk
- init_done  input  1  SD-card/SDRAM preload complete; level
- run_en  input  1  scheduling enable; level
- bk_busy  input  1  background drawer busy; level
- bk_done  input  1  background drawer finished; 1-cycle pulse
- spr_busy  input  1  sprite drawer busy; level
- spr_done  input  1  sprite drawer finished; 1-cycle pulse
- bk_start  output  1  start background pass; 1-cycle pulse
- spr_start  output  1  start sprite pass; 1-cycle pulse
- frame_flip  output  1  displayed-buffer select; toggles on each flip
- frame_count  output  CNT_W  number of flips performed; wraps
- overrun_cnt  output  8  frames missed because drawing was late; saturates at 255
- timeout_err  output  1  sticky flag, set when any task times out
- sched_busy  output  1  high while a drawing pass is in progress

Behaviour:
- Reset values:
  - bk_start=0, spr_start=0, frame_flip=0, frame_count=0, overrun_cnt=0, timeout_err=0, sched_busy=0.
  - FSM state = IDLE; timeout counter = 0; edge-detect register = 0.
- Frame edge:
  - fe = new_frame & ~new_frame_q, with new_frame_q registered every clk.
  - Exactly one fe per frame. All events below act on fe, not on the new_frame level.
- States:
  - IDLE:
    - Waits for init_done=1 and run_en=1, then goes to WAIT_FRAME.
    - fe events are ignored here: no flip, no overrun.
  - WAIT_FRAME:
    - On fe: toggle frame_flip, frame_count+1, go to START_BK.
    - If run_en=0 at fe: go to IDLE instead; no flip.
  - START_BK:
    - When bk_busy=0: assert bk_start for exactly 1 cycle and go to RUN_BK.
    - While bk_busy=1: hold.
  - RUN_BK:
    - On bk_done: go to START_SPR.
  - START_SPR / RUN_SPR:
    - Same rules as START_BK / RUN_BK, using spr_busy, spr_start and spr_done.
    - On spr_done: go to WAIT_FRAME.
- sched_busy = 1 in the START_BK, RUN_BK, START_SPR and RUN_SPR states.
- Latency: from fe to bk_start is 1 cycle (registered FSM) when bk_busy=0. frame_flip toggles on the cycle after fe.
- Overrun:
  - fe while sched_busy=1 increments overrun_cnt (saturating at 255).
  - No flip occurs and the current pass continues. That frame's flip is taken at the next fe seen in WAIT_FRAME.
  - Thus frame_flip never toggles while a pass is writing the back buffer.
- Simultaneous events:
  - fe in the same cycle as spr_done: counts as an overrun. The FSM moves to WAIT_FRAME and flips at the next fe.
  - fe in the same cycle as bk_done: counts as an overrun. The FSM proceeds to START_SPR.
- Timeout:
  - A counter clears on entry to each START_* state and increments in START_* and RUN_* states.
  - Reaching TIMEOUT_CYCLES-1 without the awaited done:
    - sets timeout_err (sticky until reset);
    - abandons the task and advances as if done (RUN_BK → START_SPR; RUN_SPR or a stuck START_* → the next state in sequence).
- Done pulses arriving in a state other than the matching RUN_* state are ignored.
- run_en=0 mid-pass: the current pass completes normally, then the FSM goes to IDLE from WAIT_FRAME at the next fe without flipping.
- init_done falling never aborts a pass.
- frame_count wraps modulo 2^CNT_W.
- Reset mid-operation:
  - All outputs return to reset values in the next cycle.
  - Start pulses deassert immediately.
  - Pending passes are forgotten; clients are responsible for their own reset.

Test Plan:
- Reset, init_done=1, run_en=1, fe → frame_flip=1, frame_count=1; bk_start 1-cycle pulse 1 cycle after fe; bk_done after 100 cycles → spr_start next cycle; spr_done → sched_busy=0.
- bk_busy held high 50 cycles after fe → bk_start asserted on the first cycle bk_busy=0, exactly one pulse.
- Withhold spr_done across 3 fe → overrun_cnt=3, frame_flip unchanged; then spr_done → flip at the next fe, frame_count+1.
- TIMEOUT_CYCLES=64, bk_done never asserted → timeout_err=1 at cycle 64 after bk_start; spr_start follows; timeout_err stays 1 until reset.
- spr_done coincident with fe → overrun_cnt+1, no flip that frame; flip on the following fe.
- init_done=0 with fe pulses → no starts, frame_flip=0; reset asserted during RUN_SPR → all outputs at reset values next cycle, FSM in IDLE.

Source files
------------

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: flips the display buffer on vblank, then runs the background
// and sprite drawing passes in order, flagging frame overruns and hung clients.
module frame_scheduler #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_frame,
    input  logic             init_done,
    input  logic             run_en,
    input  logic             bk_busy,
    input  logic             bk_done,
    input  logic             spr_busy,
    input  logic             spr_done,
    output logic             bk_start,
    output logic             spr_start,
    output logic             frame_flip,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       overrun_cnt,
    output logic             timeout_err,
    output logic             sched_busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        START_BK,
        RUN_BK,
        START_SPR,
        RUN_SPR
    } state_t;

    state_t          state;
    logic            new_frame_q;
    logic            fe;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fe     = new_frame & ~new_frame_q;
    assign to_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            new_frame_q <= 1'b0;
            to_cnt      <= '0;
            bk_start    <= 1'b0;
            spr_start   <= 1'b0;
            frame_flip  <= 1'b0;
            frame_count <= '0;
            overrun_cnt <= 8'd0;
            timeout_err <= 1'b0;
            sched_busy  <= 1'b0;
        end else begin
            new_frame_q <= new_frame;
            bk_start    <= 1'b0;
            spr_start   <= 1'b0;

            // A frame edge during a pass is a missed frame; the pass keeps going.
            if (fe && sched_busy)
                overrun_cnt <= sat_inc8(overrun_cnt);

            case (state)
                IDLE: begin
                    if (init_done && run_en)
                        state <= WAIT_FRAME;
                end

                WAIT_FRAME: begin
                    if (fe) begin
                        if (!run_en) begin
                            state <= IDLE;
                        end else begin
                            frame_flip  <= ~frame_flip;
                            frame_count <= frame_count + CNT_W'(1);
                            sched_busy  <= 1'b1;
                            to_cnt      <= '0;
                            if (!bk_busy) begin
                                bk_start <= 1'b1;
                                state    <= RUN_BK;
                            end else begin
                                state <= START_BK;
                            end
                        end
                    end
                end

                START_BK: begin
                    if (!bk_busy) begin
                        bk_start <= 1'b1;
                        to_cnt   <= '0;
                        state    <= RUN_BK;
                    end else if (to_hit) begin
                        timeout_err <= 1'b1;
                        to_cnt      <= '0;
                        if (!spr_busy) begin
                            spr_start <= 1'b1;
                            state     <= RUN_SPR;
                        end else begin
                            state <= START_SPR;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RUN_BK: begin
                    // A late done on the final count still counts as completion.
                    if (bk_done || to_hit) begin
                        if (!bk_done)
                            timeout_err <= 1'b1;
                        to_cnt <= '0;
                        if (!spr_busy) begin
                            spr_start <= 1'b1;
                            state     <= RUN_SPR;
                        end else begin
                            state <= START_SPR;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                START_SPR: begin
                    if (!spr_busy) begin
                        spr_start <= 1'b1;
                        to_cnt    <= '0;
                        state     <= RUN_SPR;
                    end else if (to_hit) begin
                        timeout_err <= 1'b1;
                        sched_busy  <= 1'b0;
                        state       <= WAIT_FRAME;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RUN_SPR: begin
                    if (spr_done || to_hit) begin
                        if (!spr_done)
                            timeout_err <= 1'b1;
                        sched_busy <= 1'b0;
                        state      <= WAIT_FRAME;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: per-cycle vector table for the basic flow,
// then hand sequences for stalls, overruns, timeouts and reset.
module tb_frame_scheduler;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset, new_frame, init_done, run_en;
    logic bk_busy, bk_done, spr_busy, spr_done;

    logic          bk_start, spr_start, frame_flip, timeout_err, sched_busy;
    logic [CW-1:0] frame_count;
    logic [7:0]    overrun_cnt;

    logic          bk_start64, spr_start64, frame_flip64, timeout_err64, sched_busy64;
    logic [CW-1:0] frame_count64;
    logic [7:0]    overrun_cnt64;

    int n_pass  = 0;
    int n_total = 0;
    int bk_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (bk_start) bk_pulses++;

    frame_scheduler #(.TIMEOUT_CYCLES(2000), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .init_done(init_done),
        .run_en(run_en), .bk_busy(bk_busy), .bk_done(bk_done), .spr_busy(spr_busy),
        .spr_done(spr_done), .bk_start(bk_start), .spr_start(spr_start),
        .frame_flip(frame_flip), .frame_count(frame_count), .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err), .sched_busy(sched_busy)
    );

    frame_scheduler #(.TIMEOUT_CYCLES(64), .CNT_W(CW)) u_dut64 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .init_done(init_done),
        .run_en(run_en), .bk_busy(bk_busy), .bk_done(bk_done), .spr_busy(spr_busy),
        .spr_done(spr_done), .bk_start(bk_start64), .spr_start(spr_start64),
        .frame_flip(frame_flip64), .frame_count(frame_count64), .overrun_cnt(overrun_cnt64),
        .timeout_err(timeout_err64), .sched_busy(sched_busy64)
    );

    typedef struct packed {
        logic       nf, bb, bd, sb, sd;
        logic [7:0] exp;   // {bk_start, spr_start, frame_flip, sched_busy, frame_count}
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic nf, bb, bd, sb, sd, bs, ss, fl, bu,
                                input logic [3:0] cnt);
        vec_t v;
        v.nf = nf; v.bb = bb; v.bd = bd; v.sb = sb; v.sd = sd;
        v.exp = {bs, ss, fl, bu, cnt};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fe_on();
        new_frame = 1'b1;
        cyc(1);
    endtask

    task automatic fe_off();
        cyc(1);
        new_frame = 1'b0;
    endtask

    task automatic frame_pulse();
        fe_on();
        fe_off();
        cyc(1);
    endtask

    task automatic pulse_bk_done();
        bk_done = 1'b1;
        cyc(1);
        bk_done = 1'b0;
    endtask

    task automatic pulse_spr_done();
        spr_done = 1'b1;
        cyc(1);
        spr_done = 1'b0;
    endtask

    task automatic finish_pass();
        pulse_bk_done();
        cyc(1);
        pulse_spr_done();
        cyc(1);
    endtask

    initial begin
        int p;
        reset = 1'b1; new_frame = 1'b0; init_done = 1'b0; run_en = 1'b0;
        bk_busy = 1'b0; bk_done = 1'b0; spr_busy = 1'b0; spr_done = 1'b0;

        vecs[0]  = mk(0,0,0,0,0, 0,0,0,0, 4'd0);
        vecs[1]  = mk(1,0,0,0,0, 1,0,1,1, 4'd1);
        vecs[2]  = mk(1,0,0,0,0, 0,0,1,1, 4'd1);
        vecs[3]  = mk(0,0,1,0,0, 0,1,1,1, 4'd1);
        vecs[4]  = mk(0,0,0,1,0, 0,0,1,1, 4'd1);
        vecs[5]  = mk(0,0,0,0,1, 0,0,1,0, 4'd1);
        vecs[6]  = mk(1,1,0,0,0, 0,0,0,1, 4'd2);
        vecs[7]  = mk(1,1,0,0,0, 0,0,0,1, 4'd2);
        vecs[8]  = mk(0,0,0,0,0, 1,0,0,1, 4'd2);
        vecs[9]  = mk(0,0,1,1,0, 0,0,0,1, 4'd2);
        vecs[10] = mk(0,0,0,0,0, 0,1,0,1, 4'd2);
        vecs[11] = mk(0,0,1,0,0, 0,0,0,1, 4'd2);
        vecs[12] = mk(0,0,0,0,1, 0,0,0,0, 4'd2);
        vecs[13] = mk(0,0,0,0,1, 0,0,0,0, 4'd2);

        cyc(2);
        chk("reset_outputs", 32'({bk_start, spr_start, frame_flip, frame_count,
                                 overrun_cnt, timeout_err, sched_busy}), 32'd0);
        chk("reset_timeout64", 32'(timeout_err64), 32'd0);

        // Basic flow, one vector per clock
        reset = 1'b0; init_done = 1'b1; run_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            new_frame = vecs[i].nf; bk_busy = vecs[i].bb; bk_done = vecs[i].bd;
            spr_busy  = vecs[i].sb; spr_done = vecs[i].sd;
            cyc(1);
            chk($sformatf("vec%0d", i), 32'({bk_start, spr_start, frame_flip, sched_busy, frame_count}),
                32'(vecs[i].exp));
        end
        new_frame = 1'b0; bk_busy = 1'b0; bk_done = 1'b0; spr_busy = 1'b0; spr_done = 1'b0;
        cyc(1);

        // Long background pass
        fe_on();
        chk("a_bk_start", 32'(bk_start), 32'd1);
        chk("a_flip_cnt", 32'({frame_flip, frame_count}), 32'({1'b1, 4'd3}));
        fe_off();
        chk("a_bk_start_once", 32'(bk_start), 32'd0);
        cyc(98);
        chk("a_wait_bk", 32'({spr_start, sched_busy}), 32'b01);
        pulse_bk_done();
        chk("a_spr_start", 32'(spr_start), 32'd1);
        cyc(1);
        chk("a_spr_start_once", 32'(spr_start), 32'd0);
        pulse_spr_done();
        chk("a_idle_busy", 32'(sched_busy), 32'd0);

        // Background client busy for 50 cycles after the frame edge
        bk_busy = 1'b1;
        p = bk_pulses;
        fe_on();
        fe_off();
        cyc(48);
        chk("b_no_start_while_busy", 32'(bk_pulses - p), 32'd0);
        bk_busy = 1'b0;
        cyc(1);
        chk("b_bk_start", 32'(bk_start), 32'd1);
        cyc(1);
        chk("b_single_pulse", 32'(bk_pulses - p), 32'd1);
        chk("b_flip_cnt", 32'({frame_flip, frame_count}), 32'({1'b0, 4'd4}));
        pulse_bk_done();
        cyc(1);

        // Sprite pass stalled over three frames
        repeat (3) frame_pulse();
        chk("c_overrun3", 32'(overrun_cnt), 32'd3);
        chk("c_no_flip", 32'({frame_flip, frame_count, sched_busy}), 32'({1'b0, 4'd4, 1'b1}));
        pulse_spr_done();
        cyc(2);
        chk("c_flip_held", 32'(frame_flip), 32'd0);
        fe_on();
        chk("c_late_flip", 32'({frame_flip, frame_count}), 32'({1'b1, 4'd5}));
        fe_off();
        finish_pass();

        // Frame edge coincident with spr_done, then with bk_done
        fe_on();
        fe_off();
        pulse_bk_done();
        cyc(1);
        new_frame = 1'b1; spr_done = 1'b1;
        cyc(1);
        spr_done = 1'b0;
        chk("e_spr_coinc_ovr", 32'(overrun_cnt), 32'd4);
        chk("e_spr_coinc_state", 32'({sched_busy, frame_flip, frame_count}), 32'({1'b0, 1'b0, 4'd6}));
        cyc(1);
        new_frame = 1'b0;
        cyc(2);
        fe_on();
        chk("e_next_flip", 32'({frame_flip, frame_count}), 32'({1'b1, 4'd7}));
        fe_off();
        finish_pass();
        fe_on();
        fe_off();
        cyc(2);
        new_frame = 1'b1; bk_done = 1'b1;
        cyc(1);
        bk_done = 1'b0;
        chk("e_bk_coinc_ovr", 32'(overrun_cnt), 32'd5);
        chk("e_bk_coinc_spr", 32'(spr_start), 32'd1);
        cyc(1);
        new_frame = 1'b0;
        pulse_spr_done();
        cyc(1);

        // frame_count wraps at 2^CW
        repeat (8) begin
            fe_on();
            fe_off();
            finish_pass();
        end
        chk("wrap_cnt", 32'({frame_flip, frame_count}), 32'({1'b0, 4'd0}));

        // run_en dropped mid-pass
        fe_on();
        fe_off();
        run_en = 1'b0;
        finish_pass();
        chk("r_pass_completes", 32'(sched_busy), 32'd0);
        frame_pulse();
        chk("r_no_flip", 32'({frame_flip, frame_count, sched_busy}), 32'({1'b1, 4'd1, 1'b0}));
        p = bk_pulses;
        frame_pulse();
        chk("r_idle_no_start", 32'(bk_pulses - p), 32'd0);
        run_en = 1'b1;
        cyc(1);
        fe_on();
        chk("r_resume_flip", 32'({frame_flip, frame_count}), 32'({1'b0, 4'd2}));
        fe_off();

        // overrun_cnt saturation
        repeat (256) frame_pulse();
        chk("ovr_saturate", 32'(overrun_cnt), 32'd255);
        finish_pass();

        // Timeout on the 64-cycle instance
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        fe_on();
        chk("t_bk_start", 32'(bk_start64), 32'd1);
        fe_off();
        cyc(62);
        chk("t_before_limit", 32'({timeout_err64, spr_start64}), 32'b00);
        cyc(1);
        chk("t_at_limit", 32'({timeout_err64, spr_start64}), 32'b11);
        pulse_spr_done();
        cyc(1);
        fe_on();
        fe_off();
        finish_pass();
        chk("t_sticky", 32'(timeout_err64), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t_cleared", 32'(timeout_err64), 32'd0);

        // Not initialised: frame edges ignored
        reset = 1'b1; init_done = 1'b0;
        cyc(2);
        reset = 1'b0;
        p = bk_pulses;
        frame_pulse();
        frame_pulse();
        chk("i_no_start", 32'(bk_pulses - p), 32'd0);
        chk("i_no_flip", 32'({frame_flip, sched_busy}), 32'd0);

        // Reset during the sprite pass
        init_done = 1'b1;
        cyc(1);
        fe_on();
        fe_off();
        pulse_bk_done();
        chk("x_in_spr", 32'({spr_start, sched_busy}), 32'b11);
        reset = 1'b1;
        cyc(1);
        chk("x_reset_outputs", 32'({bk_start, spr_start, frame_flip, frame_count,
                                   overrun_cnt, timeout_err, sched_busy}), 32'd0);
        reset = 1'b0; init_done = 1'b0;
        p = bk_pulses;
        frame_pulse();
        chk("x_back_idle", 32'({frame_flip, 4'(bk_pulses - p)}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
